// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_frame_ctrl
// Purpose  : Frame sequencer for the conv-encoder / channel / Viterbi chain.
//            Feeds payload then zero tail bits to the encoder, flushes the
//            decoder, aligns decoded bits against a delayed copy of the sent
//            bits and keeps frame / bit-error counters.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             src_valid,
    input  logic             src_data,
    output logic             src_ready,
    output logic             enc_bit_o,
    output logic             enc_en_o,
    input  logic             dec_bit_i,
    output logic             out_valid,
    output logic             out_data,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] frame_ct,
    output logic [CNT_W-1:0] bit_err_ct
);

    localparam int PL_W = $clog2(FRAME_LEN + 1);
    localparam int TL_W = $clog2(TAIL_LEN + 1);
    localparam int DL_W = $clog2(DEC_LAT + 1);

    localparam logic [PL_W-1:0] c_PL_LAST = PL_W'(FRAME_LEN - 1);
    localparam logic [TL_W-1:0] c_TL_LAST = TL_W'(TAIL_LEN - 1);
    localparam logic [DL_W-1:0] c_DL_LAST = DL_W'(DEC_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_PAYLOAD = 3'd1;
    localparam logic [2:0] c_S_TAIL    = 3'd2;
    localparam logic [2:0] c_S_DRAIN   = 3'd3;
    localparam logic [2:0] c_S_DONE    = 3'd4;

    logic [2:0]         r_state;
    logic [PL_W-1:0]    r_pl_cnt;
    logic [TL_W-1:0]    r_tl_cnt;
    logic [DL_W-1:0]    r_dl_cnt;
    logic               r_err_flag;
    logic               r_enc_bit;
    logic               r_enc_en;
    logic               r_enc_tag;
    logic [DEC_LAT-1:0] r_dly_tag;
    logic [DEC_LAT-1:0] r_dly_bit;
    logic [CNT_W-1:0]   r_frame_ct;
    logic [CNT_W-1:0]   r_bit_err_ct;

    logic w_in_payload;
    logic w_out_valid;
    logic w_bit_err;

    assign w_in_payload = (r_state == c_S_PAYLOAD);
    assign w_out_valid  = r_dly_tag[DEC_LAT-1];
    assign w_bit_err    = w_out_valid && (dec_bit_i != r_dly_bit[DEC_LAT-1]);

    assign src_ready  = w_in_payload;
    assign busy       = (r_state != c_S_IDLE);
    assign done       = (r_state == c_S_DONE);
    assign enc_bit_o  = r_enc_bit;
    assign enc_en_o   = r_enc_en;
    assign out_valid  = w_out_valid;
    // Gated so the output stays quiet outside qualified beats.
    assign out_data   = w_out_valid & dec_bit_i;
    assign err_flag   = r_err_flag;
    assign frame_ct   = r_frame_ct;
    assign bit_err_ct = r_bit_err_ct;

    // Frame sequencing: phase counters, state transitions and underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_pl_cnt   <= '0;
            r_tl_cnt   <= '0;
            r_dl_cnt   <= '0;
            r_err_flag <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state    <= c_S_PAYLOAD;
                        r_pl_cnt   <= '0;
                        r_tl_cnt   <= '0;
                        r_dl_cnt   <= '0;
                        r_err_flag <= 1'b0;
                    end
                end
                c_S_PAYLOAD: begin
                    if (src_valid) begin
                        r_pl_cnt <= r_pl_cnt + 1'b1;
                        if (r_pl_cnt == c_PL_LAST) r_state <= c_S_TAIL;
                    end else begin
                        r_err_flag <= 1'b1;
                    end
                end
                c_S_TAIL: begin
                    r_tl_cnt <= r_tl_cnt + 1'b1;
                    if (r_tl_cnt == c_TL_LAST) r_state <= c_S_DRAIN;
                end
                c_S_DRAIN: begin
                    r_dl_cnt <= r_dl_cnt + 1'b1;
                    if (r_dl_cnt == c_DL_LAST) r_state <= c_S_DONE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Encoder drive: accepted payload bits pass through, everything else is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_bit <= 1'b0;
            r_enc_en  <= 1'b0;
            r_enc_tag <= 1'b0;
        end else begin
            r_enc_bit <= w_in_payload & src_valid & src_data;
            r_enc_en  <= w_in_payload || (r_state == c_S_TAIL) || (r_state == c_S_DRAIN);
            r_enc_tag <= w_in_payload & src_valid;
        end
    end

    // Reference delay line matching the encoder-to-decoder latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly_tag <= '0;
            r_dly_bit <= '0;
        end else begin
            r_dly_tag <= {r_dly_tag[DEC_LAT-2:0], r_enc_tag};
            r_dly_bit <= {r_dly_bit[DEC_LAT-2:0], r_enc_bit};
        end
    end

    // Scoreboard counters, both saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_ct   <= '0;
            r_bit_err_ct <= '0;
        end else begin
            if (done && (r_frame_ct != c_CNT_MAX))
                r_frame_ct <= r_frame_ct + 1'b1;
            if (w_bit_err && (r_bit_err_ct != c_CNT_MAX))
                r_bit_err_ct <= r_bit_err_ct + 1'b1;
        end
    end

endmodule
`default_nettype wire
